// File: rtl/pipe_track.sv
// Write-back destination tracker for the ID/EX, EX/MEM and MEM/WB boundaries.
// Exports per-stage write info to the hazard unit and drives the GRF write port from WB.
module pipe_track #(
  parameter int TNEW_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifStall,
  input  logic              ifWrGrf_Id,
  input  logic [4:0]        grfWa_Id,
  input  logic [TNEW_W-1:0] tNew_Id,
  input  logic [1:0]        wdSel_Id,
  input  logic [DATA_W-1:0] grfWd_Id,
  input  logic [DATA_W-1:0] pc_Id,
  input  logic [DATA_W-1:0] aluRes_Ex,
  input  logic [DATA_W-1:0] dmRd_Mem,
  output logic              ifWrGrf_IdToEx,
  output logic [4:0]        grfWa_IdToEx,
  output logic [TNEW_W-1:0] tNew_IdToEx,
  output logic [DATA_W-1:0] grfWd_IdToEx,
  output logic              ifWrGrf_ExToMem,
  output logic [4:0]        grfWa_ExToMem,
  output logic [TNEW_W-1:0] tNew_ExToMem,
  output logic [DATA_W-1:0] grfWd_ExToMem,
  output logic              ifWrGrf_MemToWb,
  output logic [4:0]        grfWa_MemToWb,
  output logic [TNEW_W-1:0] tNew_MemToWb,
  output logic [DATA_W-1:0] grfWd_MemToWb,
  output logic              grfWe,
  output logic [4:0]        grfWa,
  output logic [DATA_W-1:0] grfWd,
  output logic [DATA_W-1:0] pc_Wb
);

  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_DM  = 2'd2;

  // ID/EX
  logic              r_we_ex;
  logic [4:0]        r_wa_ex;
  logic [TNEW_W-1:0] r_tnew_ex;
  logic [1:0]        r_sel_ex;
  logic [DATA_W-1:0] r_wd_ex;
  logic [DATA_W-1:0] r_pc_ex;
  // EX/MEM
  logic              r_we_mem;
  logic [4:0]        r_wa_mem;
  logic [TNEW_W-1:0] r_tnew_mem;
  logic [1:0]        r_sel_mem;
  logic [DATA_W-1:0] r_wd_mem;
  logic [DATA_W-1:0] r_pc_mem;
  // MEM/WB
  logic              r_we_wb;
  logic [4:0]        r_wa_wb;
  logic [TNEW_W-1:0] r_tnew_wb;
  logic [DATA_W-1:0] r_wd_wb;
  logic [DATA_W-1:0] r_pc_wb;

  logic [TNEW_W-1:0] w_tnew_ex_dec;
  logic [TNEW_W-1:0] w_tnew_mem_dec;
  logic [DATA_W-1:0] w_wd_mem_next;
  logic [DATA_W-1:0] w_wd_wb_next;

  // tNew counts down by one per boundary and saturates at zero
  assign w_tnew_ex_dec  = (r_tnew_ex  == '0) ? '0 : r_tnew_ex  - 1'b1;
  assign w_tnew_mem_dec = (r_tnew_mem == '0) ? '0 : r_tnew_mem - 1'b1;

  assign w_wd_mem_next = (r_sel_ex  == SEL_ALU) ? aluRes_Ex : r_wd_ex;
  assign w_wd_wb_next  = (r_sel_mem == SEL_DM)  ? dmRd_Mem  : r_wd_mem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we_ex    <= 1'b0;
      r_wa_ex    <= '0;
      r_tnew_ex  <= '0;
      r_sel_ex   <= '0;
      r_wd_ex    <= '0;
      r_pc_ex    <= '0;
      r_we_mem   <= 1'b0;
      r_wa_mem   <= '0;
      r_tnew_mem <= '0;
      r_sel_mem  <= '0;
      r_wd_mem   <= '0;
      r_pc_mem   <= '0;
      r_we_wb    <= 1'b0;
      r_wa_wb    <= '0;
      r_tnew_wb  <= '0;
      r_wd_wb    <= '0;
      r_pc_wb    <= '0;
    end else begin
      if (ifStall) begin
        r_we_ex   <= 1'b0;
        r_wa_ex   <= '0;
        r_tnew_ex <= '0;
        r_sel_ex  <= '0;
        r_wd_ex   <= '0;
        r_pc_ex   <= '0;
      end else begin
        r_we_ex   <= ifWrGrf_Id;
        r_wa_ex   <= grfWa_Id;
        r_tnew_ex <= tNew_Id;
        r_sel_ex  <= wdSel_Id;
        r_wd_ex   <= grfWd_Id;
        r_pc_ex   <= pc_Id;
      end
      // Downstream stages never stall; a bubble simply flows through
      r_we_mem   <= r_we_ex;
      r_wa_mem   <= r_wa_ex;
      r_tnew_mem <= w_tnew_ex_dec;
      r_sel_mem  <= r_sel_ex;
      r_wd_mem   <= w_wd_mem_next;
      r_pc_mem   <= r_pc_ex;
      r_we_wb    <= r_we_mem;
      r_wa_wb    <= r_wa_mem;
      r_tnew_wb  <= w_tnew_mem_dec;
      r_wd_wb    <= w_wd_wb_next;
      r_pc_wb    <= r_pc_mem;
    end
  end

  assign ifWrGrf_IdToEx  = r_we_ex;
  assign grfWa_IdToEx    = r_wa_ex;
  assign tNew_IdToEx     = r_tnew_ex;
  assign grfWd_IdToEx    = r_wd_ex;
  assign ifWrGrf_ExToMem = r_we_mem;
  assign grfWa_ExToMem   = r_wa_mem;
  assign tNew_ExToMem    = r_tnew_mem;
  assign grfWd_ExToMem   = r_wd_mem;
  assign ifWrGrf_MemToWb = r_we_wb;
  assign grfWa_MemToWb   = r_wa_wb;
  assign tNew_MemToWb    = r_tnew_wb;
  assign grfWd_MemToWb   = r_wd_wb;

  // $zero is never written even when the instruction claims a write
  assign grfWe = r_we_wb & (r_wa_wb != 5'd0);
  assign grfWa = r_wa_wb;
  assign grfWd = r_wd_wb;
  assign pc_Wb = r_pc_wb;

endmodule

// File: tb/tb_pipe_track.sv
// Table-driven bench for pipe_track: each record is one ID-stage input cycle and
// the stage contents expected right after that clock edge.
module tb_pipe_track;

  logic        clk;
  logic        reset;
  logic        ifStall;
  logic        ifWrGrf_Id;
  logic [4:0]  grfWa_Id;
  logic [4:0]  tNew_Id;
  logic [1:0]  wdSel_Id;
  logic [31:0] grfWd_Id;
  logic [31:0] pc_Id;
  logic [31:0] aluRes_Ex;
  logic [31:0] dmRd_Mem;
  logic        ifWrGrf_IdToEx, ifWrGrf_ExToMem, ifWrGrf_MemToWb;
  logic [4:0]  grfWa_IdToEx, grfWa_ExToMem, grfWa_MemToWb;
  logic [4:0]  tNew_IdToEx, tNew_ExToMem, tNew_MemToWb;
  logic [31:0] grfWd_IdToEx, grfWd_ExToMem, grfWd_MemToWb;
  logic        grfWe;
  logic [4:0]  grfWa;
  logic [31:0] grfWd;
  logic [31:0] pc_Wb;

  int n_checks = 0;
  int n_errors = 0;

  pipe_track #(.TNEW_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ifStall(ifStall),
    .ifWrGrf_Id(ifWrGrf_Id), .grfWa_Id(grfWa_Id), .tNew_Id(tNew_Id),
    .wdSel_Id(wdSel_Id), .grfWd_Id(grfWd_Id), .pc_Id(pc_Id),
    .aluRes_Ex(aluRes_Ex), .dmRd_Mem(dmRd_Mem),
    .ifWrGrf_IdToEx(ifWrGrf_IdToEx), .grfWa_IdToEx(grfWa_IdToEx),
    .tNew_IdToEx(tNew_IdToEx), .grfWd_IdToEx(grfWd_IdToEx),
    .ifWrGrf_ExToMem(ifWrGrf_ExToMem), .grfWa_ExToMem(grfWa_ExToMem),
    .tNew_ExToMem(tNew_ExToMem), .grfWd_ExToMem(grfWd_ExToMem),
    .ifWrGrf_MemToWb(ifWrGrf_MemToWb), .grfWa_MemToWb(grfWa_MemToWb),
    .tNew_MemToWb(tNew_MemToWb), .grfWd_MemToWb(grfWd_MemToWb),
    .grfWe(grfWe), .grfWa(grfWa), .grfWd(grfWd), .pc_Wb(pc_Wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] stall, we, wa, tn, sel, wd, pc, alu, dm;
    logic [31:0] we1, wa1, tn1, wd1;
    logic [31:0] we2, wa2, tn2, wd2;
    logic [31:0] we3, wa3, tn3, wd3;
    logic [31:0] grfwe, pcwb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifStall    = v.stall[0];
    ifWrGrf_Id = v.we[0];
    grfWa_Id   = v.wa[4:0];
    tNew_Id    = v.tn[4:0];
    wdSel_Id   = v.sel[1:0];
    grfWd_Id   = v.wd;
    pc_Id      = v.pc;
    aluRes_Ex  = v.alu;
    dmRd_Mem   = v.dm;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we1"}, 32'(ifWrGrf_IdToEx), 0);
    chk({tag, "_wa1"}, 32'(grfWa_IdToEx), 0);
    chk({tag, "_tn1"}, 32'(tNew_IdToEx), 0);
    chk({tag, "_wd1"}, grfWd_IdToEx, 0);
    chk({tag, "_we2"}, 32'(ifWrGrf_ExToMem), 0);
    chk({tag, "_wa2"}, 32'(grfWa_ExToMem), 0);
    chk({tag, "_tn2"}, 32'(tNew_ExToMem), 0);
    chk({tag, "_wd2"}, grfWd_ExToMem, 0);
    chk({tag, "_we3"}, 32'(ifWrGrf_MemToWb), 0);
    chk({tag, "_wa3"}, 32'(grfWa_MemToWb), 0);
    chk({tag, "_tn3"}, 32'(tNew_MemToWb), 0);
    chk({tag, "_wd3"}, grfWd_MemToWb, 0);
    chk({tag, "_grfWe"}, 32'(grfWe), 0);
    chk({tag, "_grfWa"}, 32'(grfWa), 0);
    chk({tag, "_grfWd"}, grfWd, 0);
    chk({tag, "_pcWb"}, pc_Wb, 0);
  endtask

  initial begin
    //          stall we wa tn sel wd            pc            alu           dm
    //          | IdToEx we wa tn wd | ExToMem ... | MemToWb ... | grfWe pcWb
    vecs[0]  = '{0,1, 8,1,1,0,32'h3000,0,0,                     1, 8,1,0,            0,0,0,0,            0,0,0,0,                  0,0};
    vecs[1]  = '{0,1, 9,2,2,0,32'h3004,32'h1234,0,              1, 9,2,0,            1,8,0,32'h1234,     0,0,0,0,                  0,0};
    vecs[2]  = '{0,1,31,0,0,32'h3008,32'h3008,32'h5555,32'h7777, 1,31,0,32'h3008,     1,9,1,0,            1,8,0,32'h1234,           1,32'h3000};
    vecs[3]  = '{0,1, 0,1,1,0,32'h300C,32'h9999,32'hDEADBEEF,    1, 0,1,0,            1,31,0,32'h3008,    1,9,0,32'hDEADBEEF,       1,32'h3004};
    vecs[4]  = '{1,1,10,2,2,0,32'h3010,32'hAAAA,32'h1111,        0, 0,0,0,            1,0,0,32'hAAAA,     1,31,0,32'h3008,          1,32'h3008};
    vecs[5]  = '{1,1,10,2,2,0,32'h3010,32'hBBBB,32'h2222,        0, 0,0,0,            0,0,0,0,            1,0,0,32'hAAAA,           0,32'h300C};
    vecs[6]  = '{0,1,10,2,2,0,32'h3010,32'hCCCC,32'h3333,        1,10,2,0,            0,0,0,0,            0,0,0,0,                  0,0};
    vecs[7]  = '{0,0, 0,0,0,0,0,32'h40,0,                        0, 0,0,0,            1,10,1,0,           0,0,0,0,                  0,0};
    vecs[8]  = '{0,0, 0,0,0,0,0,0,32'hCAFEF00D,                  0, 0,0,0,            0,0,0,0,            1,10,0,32'hCAFEF00D,      1,32'h3010};
    vecs[9]  = '{0,1, 5,3,3,32'h55,32'h3014,0,0,                 1, 5,3,32'h55,       0,0,0,0,            0,0,0,0,                  0,0};
    vecs[10] = '{0,0, 0,0,0,0,0,32'h66,0,                        0, 0,0,0,            1,5,2,32'h55,       0,0,0,0,                  0,0};
    vecs[11] = '{0,0, 0,0,0,0,0,0,32'h77,                        0, 0,0,0,            0,0,0,0,            1,5,1,32'h55,             1,32'h3014};

    // Reset held two cycles with busy, non-stalling inputs
    reset = 1'b0;
    drive(vecs[2]);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    $display("reset held 2 cycles: outputs checked for zero");

    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we1", i), 32'(ifWrGrf_IdToEx), vecs[i].we1);
      chk($sformatf("v%0d_wa1", i), 32'(grfWa_IdToEx), vecs[i].wa1);
      chk($sformatf("v%0d_tn1", i), 32'(tNew_IdToEx), vecs[i].tn1);
      chk($sformatf("v%0d_wd1", i), grfWd_IdToEx, vecs[i].wd1);
      chk($sformatf("v%0d_we2", i), 32'(ifWrGrf_ExToMem), vecs[i].we2);
      chk($sformatf("v%0d_wa2", i), 32'(grfWa_ExToMem), vecs[i].wa2);
      chk($sformatf("v%0d_tn2", i), 32'(tNew_ExToMem), vecs[i].tn2);
      chk($sformatf("v%0d_wd2", i), grfWd_ExToMem, vecs[i].wd2);
      chk($sformatf("v%0d_we3", i), 32'(ifWrGrf_MemToWb), vecs[i].we3);
      chk($sformatf("v%0d_wa3", i), 32'(grfWa_MemToWb), vecs[i].wa3);
      chk($sformatf("v%0d_tn3", i), 32'(tNew_MemToWb), vecs[i].tn3);
      chk($sformatf("v%0d_wd3", i), grfWd_MemToWb, vecs[i].wd3);
      chk($sformatf("v%0d_grfWe", i), 32'(grfWe), vecs[i].grfwe);
      chk($sformatf("v%0d_grfWa", i), 32'(grfWa), vecs[i].wa3);
      chk($sformatf("v%0d_grfWd", i), grfWd, vecs[i].wd3);
      chk($sformatf("v%0d_pcWb", i), pc_Wb, vecs[i].pcwb);
      $display("vec %0d: stall=%0d wa_id=%0d -> IdToEx wa=%0d tn=%0d | WB we=%0d wa=%0d wd=%h",
               i, vecs[i].stall, vecs[i].wa, grfWa_IdToEx, tNew_IdToEx, grfWe, grfWa, grfWd);
    end

    // Fill the pipe, then assert reset during a stall: reset must win
    drive(vecs[0]);
    @(posedge clk);
    drive(vecs[1]);
    @(posedge clk);
    drive(vecs[2]);
    @(posedge clk);
    drive(vecs[4]);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_stall");
    $display("reset asserted mid-stall: outputs checked for zero");

    // First instruction after release lands in IdToEx one cycle later
    reset = 1'b1;
    drive(vecs[9]);
    @(posedge clk);
    #1;
    chk("rel_we1", 32'(ifWrGrf_IdToEx), 1);
    chk("rel_wa1", 32'(grfWa_IdToEx), 5);
    chk("rel_tn1", 32'(tNew_IdToEx), 3);
    chk("rel_we2", 32'(ifWrGrf_ExToMem), 0);
    $display("release: IdToEx wa=%0d tn=%0d", grfWa_IdToEx, tNew_IdToEx);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
